// File: rtl/mip_fb_pkg.sv
// Shared types for the frame-buffer arbiter: mode encodings and grant sources.
package mip_fb_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE    = 2'd0,
    MODE_FREEZE  = 2'd1,
    MODE_PROCESS = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CAP  = 2'd2,
    GNT_PROC = 2'd3
  } gnt_e;

  // Encoding 3 is not a mode; requests carrying it leave the pending mode alone.
  function automatic logic mode_is_valid(input logic [1:0] m);
    return (m == MODE_LIVE) || (m == MODE_FREEZE) || (m == MODE_PROCESS);
  endfunction

endpackage

// File: rtl/mip_sync_fifo.sv
// Capture FIFO: first-word fall-through, pointers one bit wider than the index
// so full and empty are told apart by the wrap bit. rst is async, active-low.
module mip_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                 (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_reg[rd_ptr_reg[IDX_W-1:0]];

  // Pointer update; wraps modulo 2*DEPTH naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/mip_fb_arbiter.sv
// Frame-buffer port arbiter: one single-port RAM shared by display reads,
// FIFO-buffered capture writes and processor accesses, plus the mode FSM.
// Optional statistics outputs (frame_cnt, proc_stall_cnt) under MIP_FB_STATS_EN.
module mip_fb_arbiter
  import mip_fb_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_req,
  output logic [1:0]        mode_cur,
  input  logic              cap_sof,
  input  logic              cap_valid,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [PIX_W-1:0]  cap_pix,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [PIX_W-1:0]  disp_rdata,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [PIX_W-1:0]  proc_wdata,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  output logic [PIX_W-1:0]  proc_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [CNT_W-1:0]  drop_cnt
`ifdef MIP_FB_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  proc_stall_cnt
`endif
);

  localparam int FW = ADDR_W + PIX_W;

  mode_e             mode_cur_reg, mode_cur_next;
  mode_e             pending_reg, pending_next;
  logic              live_mode, proc_mode;
  gnt_e              gnt_sel;
  logic              fifo_full, fifo_empty, cap_push, cap_pop, cap_drop;
  logic [FW-1:0]     fifo_rdata;
  logic              disp_p1_reg, proc_p1_reg;
  logic              disp_rvalid_reg, proc_rvalid_reg;
  logic [PIX_W-1:0]  disp_rdata_reg, proc_rdata_reg;
  logic [CNT_W-1:0]  drop_cnt_reg;

  // Mode state register: pending request and the mode in effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_cur_reg <= MODE_LIVE;
      pending_reg  <= MODE_LIVE;
    end else begin
      mode_cur_reg <= mode_cur_next;
      pending_reg  <= pending_next;
    end
  end

  // Next mode: latch any legal request; commit it only at a capture frame start.
  always_comb begin
    pending_next  = pending_reg;
    mode_cur_next = mode_cur_reg;
    if (mode_is_valid(mode_req)) pending_next = mode_e'(mode_req);
    if (cap_sof) mode_cur_next = pending_reg;
  end

  // Mode-derived qualifiers used by the capture path and the grant logic.
  always_comb begin
    mode_cur  = mode_cur_reg;
    live_mode = (mode_cur_reg == MODE_LIVE);
    proc_mode = (mode_cur_reg == MODE_PROCESS);
  end

  // Fixed-priority grant: display, then capture drain, then processor.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (disp_req)                    gnt_sel = GNT_DISP;
    else if (!fifo_empty)            gnt_sel = GNT_CAP;
    else if (proc_req && proc_mode)  gnt_sel = GNT_PROC;
  end

  assign cap_pop  = (gnt_sel == GNT_CAP);
  assign cap_push = cap_valid && live_mode && (!fifo_full || cap_pop);
  assign cap_drop = cap_valid && live_mode && fifo_full && !cap_pop;
  assign proc_gnt = (gnt_sel == GNT_PROC);

  mip_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_cap_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_push),
    .pop   (cap_pop),
    .wdata ({cap_addr, cap_pix}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // RAM port mux; address and data are held at zero on idle cycles.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (gnt_sel)
      GNT_DISP: begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end
      GNT_CAP: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = fifo_rdata[FW-1:PIX_W];
        ram_wdata = fifo_rdata[PIX_W-1:0];
      end
      GNT_PROC: begin
        ram_en    = 1'b1;
        ram_we    = proc_we;
        ram_addr  = proc_addr;
        ram_wdata = proc_wdata;
      end
      default: ;
    endcase
  end

  // Two-stage read return: stage 1 tracks the RAM latency, stage 2 registers the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_p1_reg     <= 1'b0;
      proc_p1_reg     <= 1'b0;
      disp_rvalid_reg <= 1'b0;
      proc_rvalid_reg <= 1'b0;
      disp_rdata_reg  <= '0;
      proc_rdata_reg  <= '0;
    end else begin
      disp_p1_reg     <= (gnt_sel == GNT_DISP);
      proc_p1_reg     <= (gnt_sel == GNT_PROC) && !proc_we;
      disp_rvalid_reg <= disp_p1_reg;
      proc_rvalid_reg <= proc_p1_reg;
      if (disp_p1_reg) disp_rdata_reg <= ram_rdata;
      if (proc_p1_reg) proc_rdata_reg <= ram_rdata;
    end
  end

  assign disp_rvalid = disp_rvalid_reg;
  assign disp_rdata  = disp_rdata_reg;
  assign proc_rvalid = proc_rvalid_reg;
  assign proc_rdata  = proc_rdata_reg;

  // Saturating count of capture pixels lost to a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          drop_cnt_reg <= '0;
    else if (cap_drop && !(&drop_cnt_reg)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
  end

  assign drop_cnt = drop_cnt_reg;

`ifdef MIP_FB_STATS_EN
  logic [CNT_W-1:0] frame_cnt_reg, proc_stall_cnt_reg;

  // Wrapping frame and processor-stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_reg      <= '0;
      proc_stall_cnt_reg <= '0;
    end else begin
      if (cap_sof) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (proc_req && proc_mode && !proc_gnt) proc_stall_cnt_reg <= proc_stall_cnt_reg + 1'b1;
    end
  end

  assign frame_cnt      = frame_cnt_reg;
  assign proc_stall_cnt = proc_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mip_fb_arbiter.sv
// Directed bench for mip_fb_arbiter with a small registered-read RAM model.
module tb_mip_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_req;
  logic [1:0]  mode_cur;
  logic        cap_sof, cap_valid;
  logic [18:0] cap_addr;
  logic [11:0] cap_pix;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        disp_rvalid;
  logic [11:0] disp_rdata;
  logic        proc_req, proc_we;
  logic [18:0] proc_addr;
  logic [11:0] proc_wdata;
  logic        proc_gnt, proc_rvalid;
  logic [11:0] proc_rdata;
  logic        ram_en, ram_we;
  logic [18:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [15:0] drop_cnt;
`ifdef MIP_FB_STATS_EN
  logic [15:0] frame_cnt, proc_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] mem [256];

  always #5 clk = ~clk;

  mip_fb_arbiter dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .mode_cur(mode_cur),
    .cap_sof(cap_sof), .cap_valid(cap_valid), .cap_addr(cap_addr), .cap_pix(cap_pix),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .drop_cnt(drop_cnt)
`ifdef MIP_FB_STATS_EN
    , .frame_cnt(frame_cnt), .proc_stall_cnt(proc_stall_cnt)
`endif
  );

  // RAM model: one-cycle registered read, write on ram_we.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven, outputs checked #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 12'hABC;
    mem[8'h05] = 12'h555;
    ram_rdata = '0;
    rst = 1'b0; mode_req = 2'd0; cap_sof = 1'b0; cap_valid = 1'b0;
    cap_addr = '0; cap_pix = '0; disp_req = 1'b0; disp_addr = '0;
    proc_req = 1'b0; proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;

    // 1: reset and idle
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_ram_en", ram_en, 0);
      chk("idle_outs", {mode_cur, disp_rvalid, proc_rvalid, proc_gnt, drop_cnt}, 0);
      tick();
    end

    // 2: display read with 2-cycle return
    disp_req = 1'b1; disp_addr = 19'h00010;
    #1;
    chk("disp_ram_en", {ram_en, ram_we}, 2'b10);
    chk("disp_ram_addr", ram_addr, 32'h10);
    tick(); disp_req = 1'b0; #1;
    chk("disp_rvalid_p1", disp_rvalid, 0);
    tick(); #1;
    chk("disp_rvalid_p2", disp_rvalid, 1);
    chk("disp_rdata", disp_rdata, 32'hABC);
    tick(); #1;
    chk("disp_rvalid_p3", disp_rvalid, 0);

    // 3: 20 captures while display owns the RAM; 8 stored, 12 dropped
    tick();
    disp_req = 1'b1; disp_addr = '0;
    for (int i = 0; i < 20; i++) begin
      cap_valid = 1'b1; cap_addr = 19'h40 + 19'(i); cap_pix = 12'h100 + 12'(i);
      tick();
    end
    cap_valid = 1'b0;
    #1;
    chk("drop_cnt_12", drop_cnt, 12);
    chk("disp_blocks_drain", ram_we, 0);
    disp_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("drain_en_we", {ram_en, ram_we}, 2'b11);
      chk("drain_addr", ram_addr, 32'h40 + j);
      chk("drain_data", ram_wdata, 32'h100 + j);
      tick();
    end
    #1;
    chk("drain_done", ram_en, 0);

    // 3b: enqueue on a full FIFO in the same cycle as a dequeue
    tick();
    disp_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cap_valid = 1'b1; cap_addr = 19'h60 + 19'(i); cap_pix = 12'h200 + 12'(i);
      tick();
    end
    disp_req = 1'b0; cap_addr = 19'h68; cap_pix = 12'h208;
    #1;
    chk("full_pop_addr", ram_addr, 32'h60);
    tick(); cap_valid = 1'b0;
    for (int j = 1; j < 9; j++) begin
      #1;
      chk("full_drain_addr", ram_addr, 32'h60 + j);
      chk("full_drain_data", ram_wdata, 32'h200 + j);
      tick();
    end
    #1;
    chk("full_no_drop", drop_cnt, 12);
    chk("full_drain_done", ram_en, 0);

    // 4: PROCESS request waits for cap_sof; encoding 3 is ignored
    mode_req = 2'd2; proc_req = 1'b1; proc_we = 1'b0; proc_addr = 19'h00005;
    tick(); mode_req = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pre_sof_mode", mode_cur, 0);
      chk("pre_sof_gnt", proc_gnt, 0);
      tick();
    end
    cap_sof = 1'b1; #1;
    chk("sof_cycle_gnt", proc_gnt, 0);
    tick(); cap_sof = 1'b0; #1;
    chk("post_sof_mode", mode_cur, 2);
    chk("proc_gnt_read", {proc_gnt, ram_en, ram_we}, 3'b110);
    chk("proc_ram_addr", ram_addr, 32'h5);
    tick(); proc_req = 1'b0; #1;
    chk("proc_rvalid_p1", proc_rvalid, 0);
    tick(); #1;
    chk("proc_rvalid_p2", proc_rvalid, 1);
    chk("proc_rdata", proc_rdata, 32'h555);
    tick(); #1;
    chk("proc_rvalid_p3", proc_rvalid, 0);
`ifdef MIP_FB_STATS_EN
    chk("frame_cnt", frame_cnt, 1);
    chk("stall_before", proc_stall_cnt, 0);
`endif

    // 5: display starves the processor for 6 cycles
    disp_req = 1'b1; proc_req = 1'b1; proc_we = 1'b1;
    proc_addr = 19'h20; proc_wdata = 12'h777;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("starved_gnt", proc_gnt, 0);
      tick();
    end
    disp_req = 1'b0; #1;
`ifdef MIP_FB_STATS_EN
    chk("stall_cnt_6", proc_stall_cnt, 6);
`endif
    chk("proc_write_gnt", {proc_gnt, ram_we}, 2'b11);
    chk("proc_write_data", ram_wdata, 32'h777);
    tick(); proc_req = 1'b0;
    tick(); #1;
    chk("write_no_rvalid", proc_rvalid, 0);

    // Non-LIVE capture is ignored and not counted as a drop
    cap_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("nonlive_cap_idle", ram_en, 0);
      tick();
    end
    cap_valid = 1'b0; #1;
    chk("nonlive_no_drop", drop_cnt, 12);

    // 6: reset in the middle of a display read
    tick();
    disp_req = 1'b1; disp_addr = 19'h10;
    tick(); disp_req = 1'b0; rst = 1'b0; #1;
    chk("rst_rvalid_0", disp_rvalid, 0);
    chk("rst_mode", mode_cur, 0);
    tick(); #1;
    chk("rst_rvalid_1", {disp_rvalid, proc_rvalid}, 0);
    tick(); rst = 1'b1; #1;
    chk("post_rst_drop", drop_cnt, 0);
    chk("post_rst_mode", mode_cur, 0);
    chk("post_rst_fifo_empty", ram_en, 0);
    tick(); #1;
    chk("post_rst_rvalid", {disp_rvalid, proc_rvalid}, 0);
    tick(); #1;
    chk("post_rst_rvalid2", {disp_rvalid, proc_rvalid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
